// File: rtl/chunked_adder.sv
// -----------------------------------------------------------------------------
// chunked_adder
//
// Multi-cycle add/subtract unit. The operands are processed one CHUNK-bit slice
// per clock, least-significant slice first. The carry is held in a register
// between slices, so the longest carry chain in any one cycle is CHUNK+1 bits,
// whatever WIDTH is. When the last slice has been added, SUM, COUT, OV and ZERO
// are updated together and done pulses for one cycle.
//
// Parameters
//   WIDTH        operand/result width; must be a multiple of CHUNK
//   CHUNK        bits processed per clock (NCHUNK = WIDTH/CHUNK slices)
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   start        request a new operation; sampled only while idle
//   sub          0: num1 + num2 + cin   1: num1 - num2 - cin (cin is borrow-in)
//   signed_mode  OV meaning: 1 = two's-complement overflow, 0 = unsigned
//                carry/borrow
//   cin          carry-in (add) or borrow-in (sub)
//   num1, num2   operands A and B
//   SUM          registered result, exact modulo 2^WIDTH
//   COUT         raw carry out of the MSB (for sub: 1 = no borrow)
//   OV           overflow flag, meaning chosen by signed_mode
//   ZERO         1 when SUM == 0
//   busy         operation in progress (high for NCHUNK cycles)
//   done         one-cycle pulse: SUM and the flags were just updated
// -----------------------------------------------------------------------------
module chunked_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic             signed_mode,
    input  logic             cin,
    input  logic [WIDTH-1:0] num1,
    input  logic [WIDTH-1:0] num2,
    output logic [WIDTH-1:0] SUM,
    output logic             COUT,
    output logic             OV,
    output logic             ZERO,
    output logic             busy,
    output logic             done
);

    localparam int NCHUNK = WIDTH / CHUNK;
    // Keep the slice index at least one bit wide so that NCHUNK == 1 still
    // elaborates.
    localparam int IDX_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    // Stop elaboration when the operand cannot be split into whole slices.
    generate
        if (CHUNK < 1 || WIDTH < CHUNK || (WIDTH % CHUNK) != 0) begin : g_param_check
            $error("chunked_adder: WIDTH (%0d) must be a non-zero multiple of CHUNK (%0d)",
                   WIDTH, CHUNK);
        end
    endgenerate

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;          // operand A
    logic [WIDTH-1:0] r_b;          // operand B, already inverted for subtract
    logic [WIDTH-1:0] r_res;        // working result, filled one slice at a time
    logic             r_carry;      // carry between slices
    logic             r_signed;     // latched signed_mode
    logic             r_sub;        // latched sub
    logic [IDX_W-1:0] r_idx;        // slice being added this cycle

    logic [CHUNK-1:0] w_a_slice;
    logic [CHUNK-1:0] w_b_slice;
    logic [CHUNK-1:0] w_sum_slice;
    logic             w_carry_out;
    logic             w_carry_into_msb;
    logic             w_last;
    logic             w_ov;
    logic [WIDTH-1:0] w_res_next;

    // Select the operand slices for the current index.
    // NOTE: every signal driven in always_comb gets a default first; without one,
    // any path that skips the assignment keeps the old value and infers a latch.
    always_comb begin
        w_a_slice = '0;
        w_b_slice = '0;
        for (int k = 0; k < NCHUNK; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_a_slice = r_a[k*CHUNK +: CHUNK];
                w_b_slice = r_b[k*CHUNK +: CHUNK];
            end
        end
    end

    // One CHUNK+1 bit addition per cycle. Subtraction was already turned into
    // an addition at start (B inverted, carry-in = cin ^ sub).
    assign {w_carry_out, w_sum_slice} = {1'b0, w_a_slice}
                                      + {1'b0, w_b_slice}
                                      + {{CHUNK{1'b0}}, r_carry};

    // Carry into the top bit of this slice is recovered from the sum bit:
    // s = a ^ b ^ c_in. It is only used on the last slice, where that top bit
    // is the MSB of the whole word.
    assign w_carry_into_msb = w_a_slice[CHUNK-1] ^ w_b_slice[CHUNK-1]
                            ^ w_sum_slice[CHUNK-1];

    assign w_last = (r_idx == LAST_IDX);

    // Signed: overflow when the carries into and out of the MSB differ.
    // Unsigned add: a carry out means overflow. Unsigned sub: a missing carry
    // out (a borrow) means overflow.
    assign w_ov = r_signed ? (w_carry_into_msb ^ w_carry_out)
                           : (r_sub ? ~w_carry_out : w_carry_out);

    // Working result with the slice computed this cycle merged in. The final
    // SUM is taken from this value on the last slice edge.
    always_comb begin
        w_res_next = r_res;
        for (int k = 0; k < NCHUNK; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_res_next[k*CHUNK +: CHUNK] = w_sum_slice;
            end
        end
    end

    // Control and datapath state. SUM and the flags change only on the last
    // slice edge, so they hold the previous result for the whole RUN phase.
    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples values from before the edge, whatever the statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the working registers are reset as well as the outputs, so
            // that nothing from an aborted operation is left in the design.
            r_state  <= IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_carry  <= 1'b0;
            r_signed <= 1'b0;
            r_sub    <= 1'b0;
            r_idx    <= '0;
            SUM      <= '0;
            COUT     <= 1'b0;
            OV       <= 1'b0;
            ZERO     <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_a      <= num1;
                        r_b      <= sub ? ~num2 : num2;
                        r_carry  <= cin ^ sub;
                        r_signed <= signed_mode;
                        r_sub    <= sub;
                        r_idx    <= '0;
                        busy     <= 1'b1;
                        r_state  <= RUN;
                    end
                end

                RUN: begin
                    // start is ignored here: requests are not queued.
                    r_res   <= w_res_next;
                    r_carry <= w_carry_out;
                    if (w_last) begin
                        SUM     <= w_res_next;
                        COUT    <= w_carry_out;
                        OV      <= w_ov;
                        ZERO    <= (w_res_next == '0);
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end

                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/chunked_adder.md
Name: chunked_adder

Overview:
- Parametrised multi-cycle add/subtract unit; successor to the 8-bit combinational adder in the MiniCPU datapath.
- Adds or subtracts two WIDTH-bit operands one CHUNK-bit slice per clock, least-significant slice first, with carry-in.
- Produces registered SUM, COUT, OV and ZERO, selectable signed or unsigned overflow, and a start/busy/done handshake.
- Lets the ALU support wide operands without a long carry chain in one cycle.

Parameters:
- WIDTH, 16, operand and result width in bits. Must be a multiple of CHUNK; otherwise elaboration fails.
- CHUNK, 8, bits processed per clock. NCHUNK = WIDTH/CHUNK (at least 1).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request a new operation; sampled only while idle
- sub  input  1  0 = num1+num2+cin; 1 = num1-num2-cin (cin acts as borrow-in)
- signed_mode  input  1  OV semantics: 1 = two's-complement overflow, 0 = unsigned carry/borrow
- cin  input  1  carry-in (add) or borrow-in (sub)
- num1  input  WIDTH  operand A
- num2  input  WIDTH  operand B
- SUM  output  WIDTH  registered result
- COUT  output  1  raw carry out of the MSB (for sub: 1 = no borrow)
- OV  output  1  overflow flag, see Behaviour
- ZERO  output  1  1 when SUM == 0
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse: SUM and flags just updated

Behaviour:
- Reset (asynchronous, any time): state IDLE; SUM=0, COUT=0, OV=0, ZERO=1, busy=0, done=0; working registers cleared.
- States: IDLE, RUN.
- IDLE, start=1 at edge E0:
  - Latch A=num1 and B = sub ? ~num2 : num2.
  - Latch carry = cin XOR sub.
  - Latch signed_mode and sub.
  - Chunk index = 0; busy=1 from E0; go to RUN.
- RUN, one slice per edge, index k = 0..NCHUNK-1:
  - {c, s} = A[k] + B[k] + carry, computed CHUNK+1 bits wide.
  - s is written into the working result slice k; carry = c.
  - For k = NCHUNK-1, also capture the carry into bit WIDTH-1.
- Final slice edge EN (N = NCHUNK edges after E0):
  - SUM = working result; COUT = final carry; ZERO = (working result == 0).
  - OV = signed_mode ? (carry into MSB XOR carry out of MSB) : (sub ? ~COUT : COUT).
  - busy=0, done=1 for exactly one cycle; return to IDLE.
- Latency: start accepted at E0, done high in the cycle after EN, i.e. NCHUNK cycles. busy is high for exactly NCHUNK cycles.
- SUM and flags hold the previous result throughout RUN and change only at the final edge. They hold until the next completion or reset.
- start while busy=1 is ignored (no queueing). Operand and mode inputs are don't-care after E0.
- start high in the done cycle is accepted (state is IDLE): back-to-back throughput is one result per NCHUNK cycles.
- NCHUNK=1: single RUN edge, latency 1.
- Reset mid-RUN: abort, no done pulse, outputs at reset values.
- Result is exact modulo 2^WIDTH; no saturation.

Test Plan (WIDTH=16, CHUNK=8 unless noted):
1. Unsigned add 0x00FF + 0x0001, cin=0 -> carry crosses slice boundary:
   - SUM=0x0100, COUT=0, OV=0, ZERO=0.
   - busy high 2 cycles; done pulses 2 cycles after start edge.
2. Unsigned add 0xFFFF + 0x0001 -> SUM=0x0000, COUT=1, OV=1, ZERO=1. With cin=1: SUM=0x0001, ZERO=0.
3. signed_mode=1, 0x7FFF + 0x0001 -> SUM=0x8000, COUT=0, OV=1. Then 0x8000 + 0xFFFF -> SUM=0x7FFF, COUT=1, OV=1.
4. sub=1, 0x0005 - 0x0007:
   - signed_mode=0 -> SUM=0xFFFE, COUT=0, OV=1 (borrow).
   - signed_mode=1 -> same SUM, OV=0.
   - 0x0007 - 0x0005, cin=1 -> SUM=0x0001, COUT=1, OV=0.
5. Handshake and reset:
   - start pulsed again while busy with different operands -> ignored; first result delivered.
   - start held high through done -> second operation begins immediately.
   - rst asserted mid-RUN -> SUM=0, ZERO=1, busy=0, no done pulse.
6. WIDTH=8, CHUNK=8, 0x80 + 0x80 unsigned -> SUM=0x00, COUT=1, OV=1, ZERO=1; done 1 cycle after start edge.
